// File: rtl/pc_ctrl_pkg.sv
// Shared constants and types for the PC redirect controller.
// Source codes double as priority: a larger code wins.
package pc_ctrl_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] SRC_EJ      = 2'd0;
    localparam logic [1:0] SRC_BR      = 2'd1;
    localparam logic [1:0] SRC_MISPRED = 2'd2;
    localparam logic [1:0] SRC_CSR     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect request/response bundle between redirect sources, PC register and the controller.
interface pc_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            csr_valid;
    logic [XLEN-1:0] csr_addr;
    logic            mispred_valid;
    logic [XLEN-1:0] mispred_pc;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            ej_valid;
    logic [XLEN-1:0] ej_pc;
    logic [XLEN-1:0] ej_offset;
    logic            stall;
    logic            fetch_ready;

    logic             pc_load;
    logic [XLEN-1:0]  pc_load_addr;
    logic [1:0]       redirect_src;
    logic             flush_if;
    logic             flush_ex;
    logic             busy;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output csr_valid, csr_addr, mispred_valid, mispred_pc, br_valid, br_target,
               ej_valid, ej_pc, ej_offset, stall, fetch_ready,
        input  pc_load, pc_load_addr, redirect_src, flush_if, flush_ex, busy, redirect_cnt
    );

    modport slave (
        input  csr_valid, csr_addr, mispred_valid, mispred_pc, br_valid, br_target,
               ej_valid, ej_pc, ej_offset, stall, fetch_ready,
        output pc_load, pc_load_addr, redirect_src, flush_if, flush_ex, busy, redirect_cnt
    );
endinterface

// File: rtl/redirect_prio_mux.sv
// Combinational priority select of the redirect sources and their target arithmetic.
module redirect_prio_mux
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            csr_valid,
    input  logic [XLEN-1:0] csr_addr,
    input  logic            mispred_valid,
    input  logic [XLEN-1:0] mispred_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            ej_valid,
    input  logic [XLEN-1:0] ej_pc,
    input  logic [XLEN-1:0] ej_offset,
    output logic            win_valid,
    output logic [1:0]      win_src,
    output logic [XLEN-1:0] win_addr
);

    always_comb begin
        win_valid = 1'b0;
        win_src   = SRC_EJ;
        win_addr  = '0;
        if (csr_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_CSR;
            win_addr  = csr_addr;
        end else if (mispred_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_MISPRED;
            win_addr  = mispred_pc + XLEN'(4);
        end else if (br_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_BR;
            win_addr  = br_target;
        end else if (ej_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_EJ;
            win_addr  = ej_pc + ej_offset - XLEN'(4);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: latches the winning redirect, holds it until the PC register
// accepts it, then raises the pipeline flush window and counts accepted redirects.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst_n,
    pc_redirect_ctrl_if.slave bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t           state_q, state_d;
    logic             pc_load_q, pc_load_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [1:0]       src_q, src_d;
    logic             flush_if_q, flush_if_d;
    logic             flush_ex_q, flush_ex_d;
    logic             keep_q, keep_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    logic            ej_allow;
    logic            win_valid;
    logic [1:0]      win_src;
    logic [XLEN-1:0] win_addr;
    logic            xfer;

    assign ej_allow = !bus.stall && (state_q != ST_FLUSH);
    assign xfer     = pc_load_q && bus.fetch_ready;

    redirect_prio_mux #(.XLEN(XLEN)) u_mux (
        .csr_valid     (bus.csr_valid),
        .csr_addr      (bus.csr_addr),
        .mispred_valid (bus.mispred_valid),
        .mispred_pc    (bus.mispred_pc),
        .br_valid      (bus.br_valid),
        .br_target     (bus.br_target),
        .ej_valid      (bus.ej_valid && ej_allow),
        .ej_pc         (bus.ej_pc),
        .ej_offset     (bus.ej_offset),
        .win_valid     (win_valid),
        .win_src       (win_src),
        .win_addr      (win_addr)
    );

    always_comb begin
        state_d    = state_q;
        pc_load_d  = pc_load_q;
        addr_d     = addr_q;
        src_d      = src_q;
        flush_if_d = flush_if_q;
        flush_ex_d = flush_ex_q;
        keep_d     = keep_q;
        fcnt_d     = fcnt_q;
        rcnt_d     = rcnt_q;
        unique case (state_q)
            ST_RUN: begin
                flush_if_d = 1'b0;
                flush_ex_d = 1'b0;
                if (win_valid) begin
                    state_d   = ST_HOLD;
                    pc_load_d = 1'b1;
                    addr_d    = win_addr;
                    src_d     = win_src;
                    keep_d    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (xfer) begin
                    rcnt_d     = rcnt_q + CNT_W'(1);
                    flush_if_d = 1'b1;
                    flush_ex_d = (src_q != SRC_EJ);
                    keep_d     = 1'b0;
                    // CSR/MISPRED arriving with the transfer restarts HOLD; flush pulses once
                    if (win_valid && (win_src >= SRC_MISPRED)) begin
                        addr_d = win_addr;
                        src_d  = win_src;
                    end else begin
                        state_d   = ST_FLUSH;
                        pc_load_d = 1'b0;
                        fcnt_d    = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else begin
                    if (win_valid && (win_src >= src_q)) begin
                        addr_d = win_addr;
                        src_d  = win_src;
                    end
                    if (!keep_q) begin
                        flush_if_d = 1'b0;
                        flush_ex_d = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (win_valid) begin
                    state_d   = ST_HOLD;
                    pc_load_d = 1'b1;
                    addr_d    = win_addr;
                    src_d     = win_src;
                    keep_d    = 1'b1;
                end else if (fcnt_q == '0) begin
                    state_d    = ST_RUN;
                    flush_if_d = 1'b0;
                    flush_ex_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                pc_load_d  = 1'b0;
                flush_if_d = 1'b0;
                flush_ex_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_load_q  <= 1'b0;
            addr_q     <= '0;
            src_q      <= '0;
            flush_if_q <= 1'b0;
            flush_ex_q <= 1'b0;
            keep_q     <= 1'b0;
            fcnt_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_load_q  <= pc_load_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            flush_if_q <= flush_if_d;
            flush_ex_q <= flush_ex_d;
            keep_q     <= keep_d;
            fcnt_q     <= fcnt_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign bus.pc_load      = pc_load_q;
    assign bus.pc_load_addr = addr_q;
    assign bus.redirect_src = src_q;
    assign bus.flush_if     = flush_if_q;
    assign bus.flush_ex     = flush_ex_q;
    assign bus.busy         = (state_q != ST_RUN);
    assign bus.redirect_cnt = rcnt_q;

endmodule
